temp_pi_controller: RTL

//   Closed-loop stage between the serial ADC reader and the fixed-frequency PWM generator.

---
 rtl/tc_pkg.sv | 19 +
 rtl/tc_sat_clamp.sv | 29 ++
 rtl/temp_pi_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/tc_pkg.sv
// tc_pkg: shared widths, FSM state encoding and integrator limits for temp_pi_controller.
package tc_pkg;

    localparam int DATA_W = 8;
    localparam int GAIN_W = 8;
    localparam int FRAC   = 4;
    localparam int INT_W  = 16;

    localparam int ERR_W  = DATA_W + 1;
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    // One bit above the product so p + integ and integ + err*ki never wrap (INT_W <= PROD_W).
    localparam int SUM_W  = PROD_W + 1;

    localparam logic signed [INT_W-1:0] INT_MAX = INT_W'((2 ** (INT_W - 1)) - 1);
    localparam logic signed [INT_W-1:0] INT_MIN = -INT_MAX;

    typedef enum logic [2:0] {IDLE, ERR, PTERM, ITERM, SUM} state_t;

endpackage

// File: rtl/tc_sat_clamp.sv
// tc_sat_clamp: combinational clamp of a signed value into [LO, HI], truncated to OUT_W bits.
// flag reports that the input lay outside the window.
module tc_sat_clamp
    import tc_pkg::*;
#(
    parameter int                      IN_W  = SUM_W,
    parameter int                      OUT_W = DATA_W,
    parameter logic signed [IN_W-1:0] LO    = '0,
    parameter logic signed [IN_W-1:0] HI    = IN_W'((2 ** OUT_W) - 1)
) (
    input  logic signed [IN_W-1:0]  din,
    output logic        [OUT_W-1:0] value,
    output logic                    flag
);

    always_comb begin
        // NOTE: every output is given a default first, so no path leaves it unassigned and no latch is inferred.
        value = din[OUT_W-1:0];
        flag  = 1'b0;
        if (din > HI) begin
            value = HI[OUT_W-1:0];
            flag  = 1'b1;
        end else if (din < LO) begin
            value = LO[OUT_W-1:0];
            flag  = 1'b1;
        end
    end

endmodule

// File: rtl/temp_pi_controller.sv
// temp_pi_controller: per-sample saturated P(I) heater drive between the ADC reader and the PWM stage.
// Define TC_INTEGRAL_EN to build the integrator, anti-windup and ITERM state; otherwise P-only.
module temp_pi_controller
    import tc_pkg::*;
(
    input  logic              clock,
    input  logic              nReset,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample,
    input  logic              sampleValid,
    input  logic [DATA_W-1:0] setpoint,
    input  logic [GAIN_W-1:0] kp,
    input  logic [GAIN_W-1:0] ki,
    output logic [DATA_W-1:0] level,
    output logic              levelValid,
    output logic              saturated,
    output logic              busy,
    output logic              overrun
);

    state_t                   state, state_nxt;
    logic                     accept;
    logic [DATA_W-1:0]        sample_q, setpoint_q;
    logic [GAIN_W-1:0]        kp_q;
    logic signed [ERR_W-1:0]  err_q;
    logic signed [PROD_W-1:0] p_q;
    logic signed [INT_W-1:0]  integ;
    logic                     sat_hi;

    logic [GAIN_W-1:0]        gain;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  u_full, u_shift;
    logic [DATA_W-1:0]        u_level;
    logic                     u_clip;

    assign accept = sampleValid && enable && (state == IDLE);
    assign busy   = (state != IDLE);

    always_ff @(posedge clock or negedge nReset) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!nReset) begin
            state <= IDLE;
        end else if (!enable) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ERR;
            ERR:     state_nxt = PTERM;
`ifdef TC_INTEGRAL_EN
            PTERM:   state_nxt = ITERM;
            ITERM:   state_nxt = SUM;
`else
            PTERM:   state_nxt = SUM;
`endif
            SUM:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: operand and pipeline registers are always written before they are read, so they carry no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            sample_q   <= sample;
            setpoint_q <= setpoint;
            kp_q       <= kp;
        end
        if (state == ERR) begin
            err_q <= $signed({1'b0, setpoint_q}) - $signed({1'b0, sample_q});
        end
        if (state == PTERM) begin
            p_q <= prod;
        end
    end

`ifdef TC_INTEGRAL_EN
    logic [GAIN_W-1:0]       ki_q;
    logic signed [SUM_W-1:0] integ_sum;
    logic [INT_W-1:0]        integ_next;
    logic                    unused_integ_clip;
    logic                    err_pos, err_neg, windup_hold;

    always_ff @(posedge clock) begin
        if (accept) begin
            ki_q <= ki;
        end
    end

    assign gain      = (state == ITERM) ? ki_q : kp_q;
    assign integ_sum = SUM_W'(integ) + SUM_W'(prod);

    tc_sat_clamp #(
        .IN_W (SUM_W),
        .OUT_W(INT_W),
        .LO   (SUM_W'(INT_MIN)),
        .HI   (SUM_W'(INT_MAX))
    ) u_integ_clamp (
        .din  (integ_sum),
        .value(integ_next),
        .flag (unused_integ_clip)
    );

    // Hold the integrator while the output is pinned and this error would push it further into that rail.
    assign err_neg     = err_q[ERR_W-1];
    assign err_pos     = !err_q[ERR_W-1] && (err_q != '0);
    assign windup_hold = saturated && ((sat_hi && err_pos) || (!sat_hi && err_neg));

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            integ <= '0;
        end else if (!enable) begin
            integ <= '0;
        end else if ((state == ITERM) && !windup_hold) begin
            integ <= $signed(integ_next);
        end
    end
`else
    logic [GAIN_W-1:0] unused_ki;

    assign unused_ki = ki;
    assign gain      = kp_q;
    assign integ     = '0;
`endif

    // Single multiplier: kp in PTERM, ki in ITERM.
    assign prod = PROD_W'(err_q) * PROD_W'($signed({1'b0, gain}));

    assign u_full  = SUM_W'(p_q) + SUM_W'(integ);
    assign u_shift = u_full >>> FRAC;

    tc_sat_clamp #(
        .IN_W (SUM_W),
        .OUT_W(DATA_W),
        .LO   ('0),
        .HI   (SUM_W'((2 ** DATA_W) - 1))
    ) u_level_clamp (
        .din  (u_shift),
        .value(u_level),
        .flag (u_clip)
    );

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            level      <= '0;
            levelValid <= 1'b0;
            saturated  <= 1'b0;
            sat_hi     <= 1'b0;
            overrun    <= 1'b0;
        end else if (!enable) begin
            level      <= '0;
            levelValid <= 1'b0;
            saturated  <= 1'b0;
            sat_hi     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            levelValid <= (state == SUM);
            if (state == SUM) begin
                level     <= u_level;
                saturated <= u_clip;
                sat_hi    <= u_clip && !u_shift[SUM_W-1];
            end
            if (sampleValid && busy) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
